register_file: RTL and testbench

- Architectural integer register file for the single-cycle/pipelined MIPS-style datapath.
- Write port is the consumer of the write-back stage: it captures writeData (MemtoReg-selected readData or ALUResult) under RegWrite.
- Two read ports feed the decode/ALU operand path.
- Register 0 is hardwired to zero.

---
 rtl/register_file_if.sv | 24 ++
 rtl/register_file.sv | 52 +++++
 tb/tb_register_file.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// Write-back / operand-read bundle for register_file: one write port, two read ports.
// The slave modport belongs to the register file; the master side drives addresses and write data.
interface register_file_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              RegWrite;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic [ADDR_W-1:0] readReg1;
  logic [ADDR_W-1:0] readReg2;
  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;

  modport master (
    output RegWrite, writeReg, writeData, readReg1, readReg2,
    input  readData1, readData2
  );

  modport slave (
    input  RegWrite, writeReg, writeData, readReg1, readReg2,
    output readData1, readData2
  );
endinterface

// File: rtl/register_file.sv
// MIPS-style architectural register file: 1 synchronous write port, 2 combinational read ports, r0 hardwired to 0.
// Optional same-cycle write-through forwarding is enabled by defining REGFILE_WRITE_BYPASS_EN.
module register_file #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32
) (
  input logic           clk,
  input logic           rst,
  register_file_if.slave rf
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              writeEn;

  // Writes to r0 are dropped here so the stored r0 stays zero as well as its read value.
  assign writeEn = rf.RegWrite && (rf.writeReg != '0);

  // Storage: async clear of every entry; reset dominates any coincident write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (writeEn) begin
      regs[rf.writeReg] <= rf.writeData;
    end
  end

  // Read ports: stored value, optional forwarding of the in-flight write, then r0 forced to zero.
  always_comb begin
    rf.readData1 = regs[rf.readReg1];
    rf.readData2 = regs[rf.readReg2];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (!rst && writeEn && (rf.readReg1 == rf.writeReg)) begin
      rf.readData1 = rf.writeData;
    end
    if (!rst && writeEn && (rf.readReg2 == rf.writeReg)) begin
      rf.readData2 = rf.writeData;
    end
`else
    // Decode relies on split-cycle timing or external forwarding for same-cycle hazards.
`endif
    if (rf.readReg1 == '0) begin
      rf.readData1 = '0;
    end
    if (rf.readReg2 == '0) begin
      rf.readData2 = '0;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: table of write/read vectors plus hand sequences for hazard and reset cases.
module tb_register_file;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  register_file_if #(.DATA_W(32), .ADDR_W(5)) rfIf ();

  register_file #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rfIf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        regWrite;
    logic [4:0]  wReg;
    logic [31:0] wData;
    logic [4:0]  rReg1;
    logic [4:0]  rReg2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } VecRec;

  VecRec vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic writeOne(input logic we, input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    rfIf.RegWrite  = we;
    rfIf.writeReg  = addr;
    rfIf.writeData = data;
    @(posedge clk);
    #1;
    rfIf.RegWrite  = 1'b0;
  endtask

  initial begin
    rfIf.RegWrite  = 1'b0;
    rfIf.writeReg  = '0;
    rfIf.writeData = '0;
    rfIf.readReg1  = '0;
    rfIf.readReg2  = '0;

    vecs[0] = '{1'b1, 5'd3,  32'd3,         5'd3,  5'd9,  32'd3,         32'd0};
    vecs[1] = '{1'b1, 5'd9,  32'd11,        5'd3,  5'd9,  32'd3,         32'd11};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF,  5'd0,  5'd0,  32'd0,         32'd0};
    vecs[3] = '{1'b0, 5'd7,  32'd14,        5'd7,  5'd3,  32'd0,         32'd3};
    vecs[4] = '{1'b1, 5'd4,  32'd2,         5'd4,  5'd4,  32'd2,         32'd2};
    vecs[5] = '{1'b1, 5'd31, 32'hA5A5A5A5,  5'd31, 5'd30, 32'hA5A5A5A5,  32'd0};
    vecs[6] = '{1'b1, 5'd30, 32'h5A5A5A5A,  5'd31, 5'd30, 32'hA5A5A5A5,  32'h5A5A5A5A};
    vecs[7] = '{1'b1, 5'd3,  32'h12345678,  5'd3,  5'd9,  32'h12345678,  32'd11};
    vecs[8] = '{1'b0, 5'd31, 32'd0,         5'd31, 5'd4,  32'hA5A5A5A5,  32'd2};

    // Initial reset: outputs zero with no clock edge required.
    #2 rst = 1'b1;
    #1;
    rfIf.readReg1 = 5'd5;
    rfIf.readReg2 = 5'd31;
    #1;
    check("reset_rd1", rfIf.readData1, 32'd0);
    check("reset_rd2", rfIf.readData2, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table: write (or not), then read both ports after the edge.
    for (int i = 0; i < 9; i++) begin
      writeOne(vecs[i].regWrite, vecs[i].wReg, vecs[i].wData);
      rfIf.readReg1 = vecs[i].rReg1;
      rfIf.readReg2 = vecs[i].rReg2;
      #1;
      check($sformatf("vec%0d_rd1", i), rfIf.readData1, vecs[i].exp1);
      check($sformatf("vec%0d_rd2", i), rfIf.readData2, vecs[i].exp2);
    end

    // Same-cycle hazard on r4 (holds 2); port 2 reads an unrelated register.
    @(negedge clk);
    rfIf.RegWrite  = 1'b1;
    rfIf.writeReg  = 5'd4;
    rfIf.writeData = 32'd14;
    rfIf.readReg1  = 5'd4;
    rfIf.readReg2  = 5'd3;
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    check("hazard_pre_edge", rfIf.readData1, 32'd14);
`else
    check("hazard_pre_edge", rfIf.readData1, 32'd2);
`endif
    check("hazard_other_port", rfIf.readData2, 32'h12345678);
    @(posedge clk);
    #1;
    rfIf.RegWrite = 1'b0;
    #1;
    check("hazard_post_edge", rfIf.readData1, 32'd14);

    // Write aimed at r0 is never visible, not even before the edge.
    @(negedge clk);
    rfIf.RegWrite  = 1'b1;
    rfIf.writeReg  = 5'd0;
    rfIf.writeData = 32'hFFFFFFFF;
    rfIf.readReg1  = 5'd0;
    #1;
    check("r0_pre_edge", rfIf.readData1, 32'd0);
    @(posedge clk);
    #1;
    rfIf.RegWrite = 1'b0;
    #1;
    check("r0_post_edge", rfIf.readData1, 32'd0);

    // Reset mid-cycle clears previously written data immediately.
    writeOne(1'b1, 5'd5, 32'hDEADBEEF);
    rfIf.readReg1 = 5'd5;
    #1;
    check("r5_written", rfIf.readData1, 32'hDEADBEEF);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("r5_async_clear", rfIf.readData1, 32'd0);

    // Writes attempted across edges while reset is held are ignored.
    rfIf.RegWrite  = 1'b1;
    rfIf.writeReg  = 5'd6;
    rfIf.writeData = 32'd42;
    rfIf.readReg2  = 5'd6;
    #1;
    check("r6_no_bypass_in_rst", rfIf.readData2, 32'd0);
    #20;
    check("r6_during_rst", rfIf.readData2, 32'd0);
    @(negedge clk);
    rfIf.RegWrite = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("r6_after_rst", rfIf.readData2, 32'd0);
    check("r5_after_rst", rfIf.readData1, 32'd0);
    rfIf.readReg1 = 5'd3;
    #1;
    check("r3_after_rst", rfIf.readData1, 32'd0);

    writeOne(1'b1, 5'd6, 32'd42);
    #1;
    check("r6_rewrite", rfIf.readData2, 32'd42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
